// File: rtl/radix2_divider.sv
// radix2_divider: multi-cycle restoring divider (one quotient bit per clock)
// for signed and unsigned operands. Divide-by-zero and the signed overflow
// case (most negative value / -1) skip the iteration and finish in one cycle.
// Result ports read zero except while a result is being offered.
module radix2_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Two's-complement negation.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1),
  // which is still representable as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    if (sgn && v[WIDTH-1]) begin
      return negate(v);
    end else begin
      return v;
    end
  endfunction

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;      // partial remainder
  logic [WIDTH-1:0]   quo_q;      // dividend bits shifting out / quotient bits shifting in
  logic [WIDTH-1:0]   dvsr_q;     // divisor magnitude
  logic               neg_quo_q;  // operand signs differ
  logic               neg_rem_q;  // dividend negative
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic               accept_s;
  logic               div_zero_s;
  logic               overflow_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  // Acceptance and early-exit operand classification.
  always_comb begin
    accept_s   = in_valid && (state_q == S_IDLE);
    div_zero_s = (divisor == ZERO);
    overflow_s = is_signed && (dividend == MIN_NEG) && (divisor == ALL_ONE);
  end

  // One restoring step plus the sign-corrected view of its result.
  always_comb begin
    shift_s = {rem_q, quo_q[WIDTH-1]};
    diff_s  = shift_s - {1'b0, dvsr_q};
    if (!diff_s[WIDTH]) begin
      rem_d = diff_s[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shift_s[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    if (neg_quo_q) begin
      quo_fix_s = negate(quo_d);
    end else begin
      quo_fix_s = quo_d;
    end
    if (neg_rem_q) begin
      rem_fix_s = negate(rem_d);
    end else begin
      rem_fix_s = rem_d;
    end
  end

  // Control FSM with datapath and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      rem_q       <= ZERO;
      quo_q       <= ZERO;
      dvsr_q      <= ZERO;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= ZERO;
      remainder_q <= ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (div_zero_s) begin
              quotient_q  <= ALL_ONE;
              remainder_q <= dividend;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (overflow_s) begin
              quotient_q  <= dividend;
              remainder_q <= ZERO;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              rem_q     <= ZERO;
              quo_q     <= magnitude(dividend, is_signed);
              dvsr_q    <= magnitude(divisor, is_signed);
              neg_quo_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_rem_q <= is_signed && dividend[WIDTH-1];
              cnt_q     <= CNT_W'(WIDTH);
              state_q   <= S_CALC;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            quotient_q  <= quo_fix_s;
            remainder_q <= rem_fix_s;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            quotient_q  <= ZERO;
            remainder_q <= ZERO;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_DONE;
          end
        end
        default: begin
          quotient_q  <= ZERO;
          remainder_q <= ZERO;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
